// File: rtl/tensor_operand_sequencer.sv
// Runs one D = A*B + C on the tensor core: fetch A/B/C rows, launch, capture D, write D rows back.
// Latency: 1 + 6*SIZE cycles from accept to launch with zero-wait memory; then core time, SIZE write cycles, done.
// Backpressure: single outstanding read; read and write requests hold address/data stable until accepted.
module tensor_operand_sequencer #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 32,
    parameter int SIZE       = 4,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               req_valid,
    output logic                               req_ready,
    input  logic [ADDR_WIDTH-1:0]              req_addr_a,
    input  logic [ADDR_WIDTH-1:0]              req_addr_b,
    input  logic [ADDR_WIDTH-1:0]              req_addr_c,
    input  logic [ADDR_WIDTH-1:0]              req_addr_d,
    output logic                               rd_req_valid,
    input  logic                               rd_req_ready,
    output logic [ADDR_WIDTH-1:0]              rd_req_addr,
    input  logic                               rd_resp_valid,
    input  logic [SIZE*ACC_WIDTH-1:0]          rd_resp_data,
    output logic                               wr_valid,
    input  logic                               wr_ready,
    output logic [ADDR_WIDTH-1:0]              wr_addr,
    output logic [SIZE*ACC_WIDTH-1:0]          wr_data,
    output logic                               core_valid_in,
    output logic signed [DATA_WIDTH-1:0]       core_matrix_a [SIZE][SIZE],
    output logic signed [DATA_WIDTH-1:0]       core_matrix_b [SIZE][SIZE],
    output logic signed [ACC_WIDTH-1:0]        core_matrix_c [SIZE][SIZE],
    input  logic                               core_valid_out,
    input  logic signed [ACC_WIDTH-1:0]        core_matrix_d [SIZE][SIZE],
    output logic                               busy,
    output logic                               done
);
    localparam int            RW       = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam logic [RW-1:0] LAST_ROW = RW'(SIZE - 1);
    localparam logic [1:0]    SEL_A    = 2'd0;
    localparam logic [1:0]    SEL_B    = 2'd1;
    localparam logic [1:0]    SEL_C    = 2'd2;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        FIRE,
        WAIT_CORE,
        WR,
        DONE
    } state_t;

    state_t                      state;
    logic [ADDR_WIDTH-1:0]       base_a, base_b, base_c, base_d;
    logic [1:0]                  mat_sel;
    logic [RW-1:0]               row;
    logic signed [ACC_WIDTH-1:0] mat_d [SIZE][SIZE];

    logic [RW-1:0]               row_inc;
    logic [RW-1:0]               next_row;
    logic [1:0]                  next_sel;
    logic [ADDR_WIDTH-1:0]       next_base;
    logic [ADDR_WIDTH-1:0]       next_rd_addr;
    logic                        last_read;

    // Next read position is precomputed so rd_req_addr can be registered on the RD_WAIT -> RD_REQ step.
    always_comb begin
        row_inc   = row + 1'b1;
        last_read = (mat_sel == SEL_C) && (row == LAST_ROW);
        next_row  = (row == LAST_ROW) ? '0 : row_inc;
        next_sel  = (row == LAST_ROW) ? mat_sel + 2'd1 : mat_sel;
        case (next_sel)
            SEL_A:   next_base = base_a;
            SEL_B:   next_base = base_b;
            default: next_base = base_c;
        endcase
        next_rd_addr = next_base + ADDR_WIDTH'(next_row);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            req_ready     <= 1'b1;
            busy          <= 1'b0;
            done          <= 1'b0;
            rd_req_valid  <= 1'b0;
            rd_req_addr   <= '0;
            wr_valid      <= 1'b0;
            wr_addr       <= '0;
            wr_data       <= '0;
            core_valid_in <= 1'b0;
            base_a        <= '0;
            base_b        <= '0;
            base_c        <= '0;
            base_d        <= '0;
            mat_sel       <= SEL_A;
            row           <= '0;
            for (int i = 0; i < SIZE; i++) begin
                for (int j = 0; j < SIZE; j++) begin
                    core_matrix_a[i][j] <= '0;
                    core_matrix_b[i][j] <= '0;
                    core_matrix_c[i][j] <= '0;
                    mat_d[i][j]         <= '0;
                end
            end
        end else begin
            core_valid_in <= 1'b0;
            done          <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        base_a       <= req_addr_a;
                        base_b       <= req_addr_b;
                        base_c       <= req_addr_c;
                        base_d       <= req_addr_d;
                        mat_sel      <= SEL_A;
                        row          <= '0;
                        rd_req_valid <= 1'b1;
                        rd_req_addr  <= req_addr_a;
                        req_ready    <= 1'b0;
                        busy         <= 1'b1;
                        state        <= RD_REQ;
                    end
                end
                RD_REQ: begin
                    if (rd_req_ready) begin
                        rd_req_valid <= 1'b0;
                        state        <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (rd_resp_valid) begin
                        for (int j = 0; j < SIZE; j++) begin
                            case (mat_sel)
                                SEL_A:   core_matrix_a[row][j] <= rd_resp_data[j*DATA_WIDTH +: DATA_WIDTH];
                                SEL_B:   core_matrix_b[row][j] <= rd_resp_data[j*DATA_WIDTH +: DATA_WIDTH];
                                default: core_matrix_c[row][j] <= rd_resp_data[j*ACC_WIDTH +: ACC_WIDTH];
                            endcase
                        end
                        if (last_read) begin
                            core_valid_in <= 1'b1;
                            state         <= FIRE;
                        end else begin
                            row          <= next_row;
                            mat_sel      <= next_sel;
                            rd_req_addr  <= next_rd_addr;
                            rd_req_valid <= 1'b1;
                            state        <= RD_REQ;
                        end
                    end
                end
                FIRE: begin
                    state <= WAIT_CORE;
                end
                WAIT_CORE: begin
                    if (core_valid_out) begin
                        for (int i = 0; i < SIZE; i++) begin
                            for (int j = 0; j < SIZE; j++) begin
                                mat_d[i][j] <= core_matrix_d[i][j];
                            end
                        end
                        for (int j = 0; j < SIZE; j++) begin
                            wr_data[j*ACC_WIDTH +: ACC_WIDTH] <= core_matrix_d[0][j];
                        end
                        wr_addr  <= base_d;
                        wr_valid <= 1'b1;
                        row      <= '0;
                        state    <= WR;
                    end
                end
                WR: begin
                    if (wr_ready) begin
                        if (row == LAST_ROW) begin
                            wr_valid <= 1'b0;
                            done     <= 1'b1;
                            state    <= DONE;
                        end else begin
                            row     <= row_inc;
                            wr_addr <= base_d + ADDR_WIDTH'(row_inc);
                            for (int j = 0; j < SIZE; j++) begin
                                wr_data[j*ACC_WIDTH +: ACC_WIDTH] <= mat_d[row_inc][j];
                            end
                        end
                    end
                end
                DONE: begin
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tensor_operand_sequencer.sv
// Directed bench: memory and tensor-core models around the sequencer, hand-computed D rows and cycle counts.
module tb_tensor_operand_sequencer;

    logic               clk;
    logic               rst;
    logic               req_valid;
    logic               req_ready;
    logic [15:0]        req_addr_a, req_addr_b, req_addr_c, req_addr_d;
    logic               rd_req_valid;
    logic               rd_req_ready;
    logic [15:0]        rd_req_addr;
    logic               rd_resp_valid;
    logic [127:0]       rd_resp_data;
    logic               wr_valid;
    logic               wr_ready;
    logic [15:0]        wr_addr;
    logic [127:0]       wr_data;
    logic               core_valid_in;
    logic signed [15:0] core_matrix_a [4][4];
    logic signed [15:0] core_matrix_b [4][4];
    logic signed [31:0] core_matrix_c [4][4];
    logic               core_valid_out;
    logic signed [31:0] core_matrix_d [4][4];
    logic               busy;
    logic               done;

    tensor_operand_sequencer #(
        .DATA_WIDTH(16), .ACC_WIDTH(32), .SIZE(4), .ADDR_WIDTH(16)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr_a(req_addr_a), .req_addr_b(req_addr_b),
        .req_addr_c(req_addr_c), .req_addr_d(req_addr_d),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_addr(rd_req_addr),
        .rd_resp_valid(rd_resp_valid), .rd_resp_data(rd_resp_data),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .core_valid_in(core_valid_in),
        .core_matrix_a(core_matrix_a), .core_matrix_b(core_matrix_b), .core_matrix_c(core_matrix_c),
        .core_valid_out(core_valid_out), .core_matrix_d(core_matrix_d),
        .busy(busy), .done(done)
    );

    int checks = 0;
    int failures = 0;

    // Owned by the main stimulus process.
    logic [127:0] mem [0:65535];
    bit  stall = 0;
    bit  inject_stray = 0;
    int  acc_base, done_base, fire_base, wr_base, rd_base, hs_base;

    // Owned by the memory/core model process.
    int           cyc = 0;
    int           acc_cnt = 0, done_cnt = 0, fire_cnt = 0, rd_hs_cnt = 0, fire_cyc = 0;
    int           two_out_err = 0, stab_err = 0, ovl_err = 0;
    int           acc_cyc_q[$], done_cyc_q[$], wr_cyc_q[$];
    logic [15:0]  rd_log[$], wr_addr_q[$];
    logic [127:0] wr_data_q[$];
    bit           outstanding = 0, pend = 0, rd_prev_stall = 0, wr_prev_stall = 0;
    int           pend_lat = 0, core_cnt = 0, acc = 0;
    logic [15:0]  pend_addr, rd_prev_addr, wr_prev_addr;
    logic [127:0] wr_prev_data;
    logic signed [31:0] d_model [4][4];

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // Memory with optional stalls and 0-5 cycle read latency; tensor core answering 3 cycles after launch.
    initial begin
        rd_req_ready = 0; rd_resp_valid = 0; rd_resp_data = '0;
        wr_ready = 0; core_valid_out = 0;
        for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) core_matrix_d[i][j] = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                outstanding = 0; rd_prev_stall = 0; wr_prev_stall = 0; pend = 0; core_cnt = 0;
            end else begin
                if (rd_resp_valid) outstanding = 0;
                if (rd_req_valid && rd_req_ready) begin
                    if (outstanding) two_out_err++;
                    outstanding = 1; pend = 1; pend_addr = rd_req_addr;
                    pend_lat = stall ? int'($urandom_range(0, 5)) : 0;
                    rd_log.push_back(rd_req_addr);
                    rd_hs_cnt++;
                end
                if (rd_prev_stall && (!rd_req_valid || rd_req_addr != rd_prev_addr)) stab_err++;
                rd_prev_stall = rd_req_valid && !rd_req_ready;
                rd_prev_addr  = rd_req_addr;
                if (wr_prev_stall && (!wr_valid || wr_addr != wr_prev_addr || wr_data != wr_prev_data)) stab_err++;
                wr_prev_stall = wr_valid && !wr_ready;
                wr_prev_addr  = wr_addr;
                wr_prev_data  = wr_data;
                if (wr_valid && wr_ready) begin
                    wr_addr_q.push_back(wr_addr);
                    wr_data_q.push_back(wr_data);
                    wr_cyc_q.push_back(cyc);
                end
                if (core_valid_in) begin
                    fire_cnt++; fire_cyc = cyc; core_cnt = 3;
                    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) begin
                        acc = int'(core_matrix_c[i][j]);
                        for (int k = 0; k < 4; k++) acc += int'(core_matrix_a[i][k]) * int'(core_matrix_b[k][j]);
                        d_model[i][j] = acc;
                    end
                end
                if (done) begin done_cnt++; done_cyc_q.push_back(cyc); end
                if (req_valid && req_ready) begin acc_cnt++; acc_cyc_q.push_back(cyc); end
                if (req_ready == busy) ovl_err++;
            end
            @(posedge clk);
            cyc++;
            #1;
            rd_resp_valid = 0;
            core_valid_out = 0;
            if (rst) begin
                pend = 0; core_cnt = 0;
            end else begin
                if (pend) begin
                    if (pend_lat == 0) begin
                        rd_resp_valid = 1; rd_resp_data = mem[pend_addr]; pend = 0;
                    end else pend_lat--;
                end
                if (core_cnt > 0) begin
                    core_cnt--;
                    if (core_cnt == 0) begin core_valid_out = 1; core_matrix_d = d_model; end
                end
            end
            if (inject_stray) begin
                rd_resp_valid = 1; rd_resp_data = '1; core_valid_out = 1;
                for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) core_matrix_d[i][j] = 32'h1234_5678;
            end
            rd_req_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            wr_ready     = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // kind 0: identity, 1: elements 4r+j+1, 2: constant cval with junk in the unused upper half
    task automatic load16(input logic [15:0] base, input int kind, input logic [15:0] cval);
        logic [127:0] w;
        for (int r = 0; r < 4; r++) begin
            w = '0;
            for (int j = 0; j < 4; j++)
                w[j*16 +: 16] = (kind == 0) ? ((r == j) ? 16'd1 : 16'd0) :
                                (kind == 1) ? 16'(4*r + j + 1) : cval;
            if (kind == 2) w[127:64] = 64'hDEAD_BEEF_0BAD_F00D;
            mem[base + 16'(r)] = w;
        end
    endtask

    task automatic load32(input logic [15:0] base, input logic [31:0] cval);
        for (int r = 0; r < 4; r++) mem[base + 16'(r)] = {4{cval}};
    endtask

    function automatic logic [127:0] seq_row32(input int r);
        logic [127:0] v;
        for (int j = 0; j < 4; j++) v[j*32 +: 32] = 32'(4*r + j + 1);
        return v;
    endfunction

    task automatic start_req(input logic [15:0] a, b, c, d);
        int n;
        @(posedge clk); #2;
        acc_base = acc_cnt; done_base = done_cnt; fire_base = fire_cnt;
        wr_base = wr_addr_q.size(); rd_base = rd_log.size(); hs_base = rd_hs_cnt;
        req_addr_a = a; req_addr_b = b; req_addr_c = c; req_addr_d = d;
        req_valid = 1;
        n = 0;
        while (acc_cnt == acc_base && n < 100) begin @(posedge clk); n++; end
        #2 req_valid = 0;
        check_eq("accepted", 128'(acc_cnt - acc_base), 128'(1));
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (done_cnt == done_base && n < 3000) begin @(posedge clk); n++; end
        check_eq({tag, " done seen"}, 128'(done_cnt - done_base), 128'(1));
        repeat (2) @(posedge clk);
    endtask

    task automatic check_writes(input string tag, input logic [15:0] dbase, input bit seq,
                                input logic [127:0] crow);
        check_eq({tag, " wr count"}, 128'(wr_addr_q.size() - wr_base), 128'(4));
        for (int i = 0; i < 4; i++) begin
            if (wr_base + i < wr_addr_q.size()) begin
                check_eq($sformatf("%s wr_addr[%0d]", tag, i), 128'(wr_addr_q[wr_base+i]), 128'(dbase + 16'(i)));
                check_eq($sformatf("%s wr_data[%0d]", tag, i), wr_data_q[wr_base+i], seq ? seq_row32(i) : crow);
            end
        end
    endtask

    task automatic check_reads(input string tag, input logic [15:0] a, b, c);
        int errs;
        logic [15:0] exp;
        errs = 0;
        check_eq({tag, " rd count"}, 128'(rd_log.size() - rd_base), 128'(12));
        for (int m = 0; m < 3; m++) for (int r = 0; r < 4; r++) begin
            exp = ((m == 0) ? a : (m == 1) ? b : c) + 16'(r);
            if (rd_base + m*4 + r >= rd_log.size() || rd_log[rd_base + m*4 + r] != exp) errs++;
        end
        check_eq({tag, " rd order errs"}, 128'(errs), 128'(0));
    endtask

    initial begin
        int n;
        rst = 1; req_valid = 0;
        req_addr_a = '0; req_addr_b = '0; req_addr_c = '0; req_addr_d = '0;
        for (int i = 0; i < 65536; i++) mem[i] = '0;
        repeat (3) @(posedge clk);
        #2 rst = 0;
        @(negedge clk);
        check_eq("reset req_ready", 128'(req_ready), 128'(1));
        check_eq("reset busy", 128'(busy), 128'(0));
        check_eq("reset strobes", 128'({rd_req_valid, wr_valid, core_valid_in, done}), 128'(0));
        check_eq("reset rd_req_addr", 128'(rd_req_addr), 128'(0));

        // Identity: D = B, with zero-wait timing
        load16(16'h0010, 0, 16'h0); load16(16'h0020, 1, 16'h0); load32(16'h0030, 32'd0);
        start_req(16'h0010, 16'h0020, 16'h0030, 16'h0040);
        wait_done("ident");
        check_writes("ident", 16'h0040, 1'b1, '0);
        check_reads("ident", 16'h0010, 16'h0020, 16'h0030);
        check_eq("ident fire pulses", 128'(fire_cnt - fire_base), 128'(1));
        check_eq("ident fire cycle", 128'(fire_cyc - acc_cyc_q[acc_cyc_q.size()-1]), 128'(25));
        check_eq("ident first wr cycle", 128'(wr_cyc_q[wr_base] - acc_cyc_q[acc_cyc_q.size()-1]), 128'(29));
        check_eq("ident done cycle", 128'(done_cyc_q[done_cyc_q.size()-1] - acc_cyc_q[acc_cyc_q.size()-1]), 128'(33));

        // Signed accumulate: -1*2*4 + 100 = 92
        load16(16'h0050, 2, 16'hFFFF); load16(16'h0060, 2, 16'h0002); load32(16'h0070, 32'd100);
        start_req(16'h0050, 16'h0060, 16'h0070, 16'h0080);
        wait_done("signed");
        check_writes("signed", 16'h0080, 1'b0, {4{32'h0000_005C}});

        // Backpressure on every handshake
        stall = 1;
        start_req(16'h0010, 16'h0020, 16'h0030, 16'h00C0);
        wait_done("stall");
        stall = 0;
        check_writes("stall", 16'h00C0, 1'b1, '0);
        check_reads("stall", 16'h0010, 16'h0020, 16'h0030);
        check_eq("stall stability errs", 128'(stab_err), 128'(0));
        check_eq("stall two outstanding", 128'(two_out_err), 128'(0));

        // Address wrap
        load16(16'hFFFE, 0, 16'h0);
        start_req(16'hFFFE, 16'h0020, 16'h0030, 16'h0090);
        wait_done("wrap");
        check_eq("wrap rd0", 128'(rd_log[rd_base]),   128'(16'hFFFE));
        check_eq("wrap rd1", 128'(rd_log[rd_base+1]), 128'(16'hFFFF));
        check_eq("wrap rd2", 128'(rd_log[rd_base+2]), 128'(16'h0000));
        check_eq("wrap rd3", 128'(rd_log[rd_base+3]), 128'(16'h0001));
        check_writes("wrap", 16'h0090, 1'b1, '0);

        // Reset during the 5th RD_WAIT
        load16(16'h0010, 0, 16'h0);
        start_req(16'h0010, 16'h0020, 16'h0030, 16'h00A0);
        n = 0;
        while (rd_hs_cnt - hs_base < 5 && n < 200) begin @(posedge clk); n++; end
        check_eq("rst reached 5th read", 128'(rd_hs_cnt - hs_base), 128'(5));
        #2 rst = 1;
        @(negedge clk);
        check_eq("rst req_ready", 128'(req_ready), 128'(1));
        check_eq("rst busy", 128'(busy), 128'(0));
        check_eq("rst strobes", 128'({rd_req_valid, wr_valid, core_valid_in, done}), 128'(0));
        check_eq("rst operand a00", 128'(core_matrix_a[0][0]), 128'(0));
        repeat (2) @(posedge clk);
        #2 rst = 0;
        wr_base = wr_addr_q.size(); fire_base = fire_cnt;
        @(posedge clk); #2 inject_stray = 1;
        @(posedge clk); #2 inject_stray = 0;
        @(posedge clk); #2;
        check_eq("stray idle", 128'({req_ready, busy, rd_req_valid}), 128'(3'b100));
        check_eq("stray operand a00", 128'(core_matrix_a[0][0]), 128'(0));
        check_eq("stray no activity", 128'((wr_addr_q.size() - wr_base) + (fire_cnt - fire_base)), 128'(0));
        start_req(16'h0010, 16'h0020, 16'h0030, 16'h00A0);
        wait_done("post_rst");
        check_writes("post_rst", 16'h00A0, 1'b1, '0);

        // Back-to-back requests with req_valid held
        @(posedge clk); #2;
        acc_base = acc_cnt; done_base = done_cnt; wr_base = wr_addr_q.size();
        req_addr_a = 16'h0010; req_addr_b = 16'h0020; req_addr_c = 16'h0030; req_addr_d = 16'h0040;
        req_valid = 1;
        n = 0;
        while (acc_cnt - acc_base < 2 && n < 300) begin @(posedge clk); n++; end
        #2 req_valid = 0;
        n = 0;
        while (done_cnt - done_base < 2 && n < 300) begin @(posedge clk); n++; end
        check_eq("b2b accepts", 128'(acc_cnt - acc_base), 128'(2));
        check_eq("b2b done pulses", 128'(done_cnt - done_base), 128'(2));
        if (acc_cnt - acc_base >= 2 && done_cnt - done_base >= 1)
            check_eq("b2b second accept cycle", 128'(acc_cyc_q[acc_base+1]), 128'(done_cyc_q[done_base] + 1));
        check_eq("b2b writes", 128'(wr_addr_q.size() - wr_base), 128'(8));
        check_eq("ready/busy overlap", 128'(ovl_err), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tensor_operand_sequencer.md
# tensor_operand_sequencer

Drives the SM tensor core through one full matrix-multiply-accumulate (D = A×B + C) per request. It fetches A, B and C row by row over a single-outstanding memory read port and assembles the full operand matrices. It then issues a single-cycle launch to the core, captures D when the core signals completion, and writes D back row by row. It sits between the SM issue logic and the tensor core, acting as the initiator of the core's valid_in / valid_out interface.

## Interface
- DATA_WIDTH, 16, A/B element width (signed)
- ACC_WIDTH, 32, C/D element width (signed)
- SIZE, 4, square matrix dimension; one memory word holds one row
- ADDR_WIDTH, 16, row-address width
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  MMA request
- req_ready  out  1  high only in IDLE
- req_addr_a / req_addr_b / req_addr_c / req_addr_d  in  ADDR_WIDTH each  row-0 address of each matrix; row r at base+r
- rd_req_valid  out  1  read request
- rd_req_ready  in  1  memory accepts read
- rd_req_addr  out  ADDR_WIDTH  read row address
- rd_resp_valid  in  1  read data returned
- rd_resp_data  in  SIZE*ACC_WIDTH  row; element j at [j*W +: W], with W=DATA_WIDTH for A/B (upper bits ignored) and W=ACC_WIDTH for C
- wr_valid  out  1  write request
- wr_ready  in  1  memory accepts write
- wr_addr  out  ADDR_WIDTH  write row address
- wr_data  out  SIZE*ACC_WIDTH  D row r; element j at [j*ACC_WIDTH +: ACC_WIDTH]
- core_valid_in  out  1  launch pulse to the tensor core
- core_matrix_a / core_matrix_b  out  signed DATA_WIDTH [SIZE][SIZE]  assembled operands
- core_matrix_c  out  signed ACC_WIDTH [SIZE][SIZE]
- core_valid_out  in  1  core result valid
- core_matrix_d  in  signed ACC_WIDTH [SIZE][SIZE]  result, sampled when core_valid_out=1
- busy  out  1  state != IDLE
- done  out  1  one-cycle completion pulse

## Operation
- FSM states: IDLE, RD_REQ, RD_WAIT, FIRE, WAIT_CORE, WR, DONE.
- IDLE: when req_valid && req_ready, latch all four base addresses, clear mat_sel and row, and go to RD_REQ.
- RD_REQ:
  - Drive rd_req_valid=1 and rd_req_addr = base[mat_sel]+row. mat_sel order is A, B, C.
  - On rd_req_ready, go to RD_WAIT.
  - Address and valid stay stable while stalled.
- RD_WAIT:
  - On rd_resp_valid, write the row into operand register mat_sel[row].
  - If this was row SIZE-1 of C, go to FIRE.
  - Otherwise advance row, wrapping to 0 and incrementing mat_sel, and return to RD_REQ.
- FIRE: core_valid_in=1 for exactly one cycle, then go to WAIT_CORE.
- WAIT_CORE: on core_valid_out, copy core_matrix_d into the D buffer, clear row, and go to WR.
- WR:
  - Drive wr_valid=1, wr_addr = base_d+row, wr_data = D[row].
  - Advance on wr_ready; after row SIZE-1, go to DONE.
  - Signals stay stable while stalled.
- DONE: done=1 for one cycle, then go to IDLE.
- Address arithmetic is modulo 2^ADDR_WIDTH (wrap-around).
- Ignored inputs:
  - rd_resp_valid outside RD_WAIT.
  - core_valid_out outside WAIT_CORE.
  - req_valid outside IDLE.
- At most one read is outstanding; rd_req_valid=0 while in RD_WAIT.
- core_matrix_* are driven directly from the operand registers and hold their values until the next request overwrites them.

## Timing
- Reset values:
  - state=IDLE, so req_ready=1.
  - busy, done, rd_req_valid, wr_valid, core_valid_in = 0.
  - All addresses, operand registers and the D buffer = 0.
- Reset is asynchronous and may be asserted mid-operation. It aborts the operation with no further memory or core handshakes. A core result arriving afterwards is ignored.
- With zero-wait memory (ready in the same cycle, response the cycle after), each read row costs 2 cycles. Accept→FIRE therefore takes 1 + 6·SIZE cycles.
- The core responds 3 cycles after the FIRE cycle.
- Writes take 1 cycle per row. DONE follows the last write handshake.
- SIZE=4 with zero-wait memory: req accept at cycle 0, FIRE at cycle 25, core_valid_out at cycle 28, writes at cycles 29–32, done at cycle 33.
- busy is high from the cycle after accept through DONE inclusive.

## Test plan
- Identity: A=I, B rows {1,2,3,4}..{13,14,15,16}, C=0, D base 0x40. Required: writes to 0x40..0x43 equal B rows sign-extended to 32 bits, done at cycle 33, exactly one core_valid_in pulse.
- Signed accumulate: A all −1, B all 2, C all 100. Required: every D element = 92 (0x0000005C).
- Backpressure: random rd_req_ready, rd_resp latency 0–5, and random wr_ready stalls. Required: same D as the unstalled run, addr/data stable while valid and not ready, never two reads outstanding.
- Address wrap: req_addr_a=0xFFFE. Required: A reads at 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- Reset mid-read: assert rst during the 5th RD_WAIT. Required: next cycle all outputs at reset values. A fresh request then completes correctly, and a stray rd_resp_valid during IDLE is ignored.
- Back-to-back: hold req_valid high for two requests. Required: second accepted only in the cycle after DONE, req_ready=0 while busy, two done pulses.
